regfile_wb_queue: RTL and testbench

Writeback queue that owns the single write port of the 32x32 register file. It accepts results from two producers, the ALU and the memory/load unit, over valid/ready handshakes. It buffers them in order in a small FIFO and drains one entry per cycle onto the register file's `wEn`/`write_sel`/`write_data` inputs. It sits between the execute/memory stages and `regFile`, so producers never contend for the write port directly.

---
 rtl/wbq_pkg.sv | 15 +
 rtl/wbq_fifo.sv | 67 ++++++
 rtl/regfile_wb_queue.sv | 119 +++++++++++
 tb/tb_regfile_wb_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// Shared definitions for the register-file writeback queue: default widths,
// the queued entry layout and the hard-wired zero register.
package wbq_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Generic circular buffer: one push and one pop per cycle, occupancy count,
// combinational head, and the raw storage exposed for associative searches.
module wbq_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              head_o,
    output logic [CNT_W-1:0]              count_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [PTR_W-1:0]              rd_ptr_o,
    output logic [DEPTH-1:0][WIDTH-1:0]   entries_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly PTR_W bits wide, so increment wraps modulo DEPTH.
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign rd_ptr_o  = rd_ptr_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue owning the register file write port: arbitrates ALU and load
// results (load has priority), drops writes to register 0, drains one per cycle.
// Optional queued-write forwarding ports are built when WBQ_FORWARD_EN is defined.
module regfile_wb_queue #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_sel,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_sel,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              wb_stall,
    output logic              wEn,
    output logic [ADDR_W-1:0] write_sel,
    output logic [DATA_W-1:0] write_data,
`ifdef WBQ_FORWARD_EN
    input  logic [ADDR_W-1:0] fwd_sel1,
    input  logic [ADDR_W-1:0] fwd_sel2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    output logic [CNT_W-1:0]  pending
);

    import wbq_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    // Parameterised twin of wbq_entry_t so non-default widths still work.
    typedef struct packed {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t                      push_entry;
    entry_t                      head_entry;
    logic                        push, pop, grant, alu_win;
    logic                        empty, full;
    logic [CNT_W-1:0]            count;
    logic [PTR_W-1:0]            rd_ptr;
    logic [DEPTH-1:0][ENTRY_W-1:0] entries;

    assign pop   = !empty && !wb_stall;
    // Readies are held low while reset is asserted, not just after it clears.
    assign grant = reset && (!full || pop);

    assign alu_win   = alu_valid && !mem_valid;
    assign mem_ready = mem_valid && grant;
    assign alu_ready = alu_win && grant;

    assign push_entry = mem_valid ? {mem_sel, mem_data} : {alu_sel, alu_data};
    assign push       = (mem_ready || alu_ready) && (push_entry.sel != ADDR_W'(REG_ZERO));

    wbq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clock),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .rd_ptr_o    (rd_ptr),
        .entries_o   (entries)
    );

    assign wEn        = pop;
    assign write_sel  = empty ? '0 : head_entry.sel;
    assign write_data = empty ? '0 : head_entry.data;
    assign pending    = count;

`ifdef WBQ_FORWARD_EN
    // Walk oldest to youngest so the last match (the youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        entry_t           ent;
        idx       = '0;
        ent       = '0;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            ent = entries[idx];
            if (CNT_W'(i) < count) begin
                if (fwd_sel1 != ADDR_W'(REG_ZERO) && ent.sel == fwd_sel1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent.data;
                end
                if (fwd_sel2 != ADDR_W'(REG_ZERO) && ent.sel == fwd_sel2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent.data;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rd_ptr, entries};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue with a register file model
// fed from the write port; forwarding checks are added under WBQ_FORWARD_EN.
module tb_regfile_wb_queue;

    import wbq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, wb_stall;
    logic [4:0]  alu_sel, mem_sel;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, wEn;
    logic [4:0]  write_sel;
    logic [31:0] write_data;
    logic [2:0]  pending;
`ifdef WBQ_FORWARD_EN
    logic [4:0]  fwd_sel1, fwd_sel2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int n_checks = 0;
    int n_passed = 0;

    logic [31:0] rf [32];
    wbq_entry_t  wr_log [$];

    always #5 clock = ~clock;

    regfile_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_sel    (alu_sel),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_sel    (mem_sel),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .wb_stall   (wb_stall),
        .wEn        (wEn),
        .write_sel  (write_sel),
        .write_data (write_data),
`ifdef WBQ_FORWARD_EN
        .fwd_sel1   (fwd_sel1),
        .fwd_sel2   (fwd_sel2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
`endif
        .pending    (pending)
    );

    // Register file model: writes land at the rising edge when wEn is high.
    always @(posedge clock) begin
        if (wEn) begin
            wr_log.push_back('{sel: write_sel, data: write_data});
            if (write_sel != 5'd0) rf[write_sel] = write_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_passed++;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] s, input logic [31:0] d);
        alu_valid = v;
        alu_sel   = s;
        alu_data  = d;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] s, input logic [31:0] d);
        mem_valid = v;
        mem_sel   = s;
        mem_data  = d;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        reset    = 1'b0;
        wb_stall = 1'b0;
        drive_alu(1'b1, 5'd1, 32'h11);
        drive_mem(1'b0, 5'd0, 32'h0);
`ifdef WBQ_FORWARD_EN
        fwd_sel1 = 5'd0;
        fwd_sel2 = 5'd0;
`endif

        // Reset state, with a valid held to show readies stay low.
        #12;
        check("rst_pending",   pending,    3'd0);
        check("rst_wen",       wEn,        1'b0);
        check("rst_wsel",      write_sel,  5'd0);
        check("rst_wdata",     write_data, 32'h0);
        check("rst_alu_ready", alu_ready,  1'b0);
        @(negedge clock);
        drive_alu(1'b0, 5'd0, 32'h0);
        reset = 1'b1;

        // Single ALU write.
        settle();
        drive_alu(1'b1, 5'd5, 32'hFFFF_FFFF);
        #1 check("alu_ready_single", alu_ready, 1'b1);
        settle();
        drive_alu(1'b0, 5'd0, 32'h0);
        #1;
        check("single_wen",   wEn,        1'b1);
        check("single_wsel",  write_sel,  5'd5);
        check("single_wdata", write_data, 32'hFFFF_FFFF);
        settle();
        check("single_drained", pending, 3'd0);
        check("single_rf5",     rf[5],   32'hFFFF_FFFF);

        // Simultaneous valids: load wins, ALU follows.
        wr_log.delete();
        drive_mem(1'b1, 5'd3, 32'h1234_5678);
        drive_alu(1'b1, 5'd4, 32'hCAFE_F00D);
        #1;
        check("both_mem_ready", mem_ready, 1'b1);
        check("both_alu_ready", alu_ready, 1'b0);
        settle();
        drive_mem(1'b0, 5'd0, 32'h0);
        #1;
        check("both_alu_ready2", alu_ready, 1'b1);
        check("both_wsel3",      write_sel, 5'd3);
        check("both_wen3",       wEn,       1'b1);
        settle();
        drive_alu(1'b0, 5'd0, 32'h0);
        #1;
        check("both_wsel4",  write_sel,  5'd4);
        check("both_wdata4", write_data, 32'hCAFE_F00D);
        settle();
        check("both_log_n",  wr_log.size(), 2);
        check("both_log0",   wr_log[0],     {5'd3, 32'h1234_5678});
        check("both_log1",   wr_log[1],     {5'd4, 32'hCAFE_F00D});
        check("both_rf3",    rf[3],         32'h1234_5678);

        // Register 0 is consumed but never written.
        wr_log.delete();
        drive_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
        #1 check("zero_ready", alu_ready, 1'b1);
        settle();
        drive_alu(1'b0, 5'd0, 32'h0);
        #1;
        check("zero_pending", pending, 3'd0);
        check("zero_wen",     wEn,     1'b0);
        settle();
        settle();
        check("zero_log_n", wr_log.size(), 0);
        check("zero_rf0",   rf[0],         32'h0);

        // Fill under stall, then release with a simultaneous push across wrap.
        wr_log.delete();
        wb_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_alu(1'b1, 5'(10 + k), 32'hA0 + 32'(k));
            #1 check($sformatf("fill_ready%0d", k), alu_ready, 1'b1);
            settle();
        end
        drive_alu(1'b1, 5'd14, 32'hA4);
        drive_mem(1'b1, 5'd15, 32'hF);
        #1;
        check("full_pending",   pending,    3'd4);
        check("full_alu_ready", alu_ready,  1'b0);
        check("full_mem_ready", mem_ready,  1'b0);
        check("full_wen",       wEn,        1'b0);
        check("full_head_sel",  write_sel,  5'd10);
        check("full_head_data", write_data, 32'hA0);
        settle();
        drive_mem(1'b0, 5'd0, 32'h0);
        wb_stall = 1'b0;
        #1;
        check("rel_alu_ready", alu_ready, 1'b1);
        check("rel_wen",       wEn,       1'b1);
        settle();
        drive_alu(1'b0, 5'd0, 32'h0);
        #1;
        check("rel_pending", pending,   3'd4);
        check("rel_head",    write_sel, 5'd11);
        repeat (5) settle();
        check("wrap_pending", pending,       3'd0);
        check("wrap_log_n",   wr_log.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("wrap_log%0d", k), wr_log[k], {5'(10 + k), 32'hA0 + 32'(k)});
        check("wrap_rf14", rf[14], 32'hA4);

`ifdef WBQ_FORWARD_EN
        // Youngest queued write to the same register is forwarded.
        wb_stall = 1'b1;
        drive_alu(1'b1, 5'd7, 32'h1);
        settle();
        drive_alu(1'b1, 5'd7, 32'h2);
        settle();
        drive_alu(1'b0, 5'd0, 32'h0);
        fwd_sel1 = 5'd7;
        fwd_sel2 = 5'd0;
        #1;
        check("fwd_hit1",  fwd_hit1,  1'b1);
        check("fwd_data1", fwd_data1, 32'h2);
        check("fwd_hit2",  fwd_hit2,  1'b0);
        check("fwd_data2", fwd_data2, 32'h0);
        fwd_sel2 = 5'd9;
        #1 check("fwd_miss", fwd_hit2, 1'b0);
        wb_stall = 1'b0;
        repeat (3) settle();
        check("fwd_rf7", rf[7], 32'h2);
`endif

        // Reset mid-traffic: three entries queued, reset pulsed between edges.
        wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_alu(1'b1, 5'(20 + k), 32'hB0 + 32'(k));
            settle();
        end
        drive_alu(1'b0, 5'd0, 32'h0);
        #1 check("mid_pending3", pending, 3'd3);
        @(posedge clock);
        #2;
        reset    = 1'b0;
        wb_stall = 1'b0;
        drive_alu(1'b1, 5'd9, 32'h99);
        #1;
        check("mid_pending0",   pending,    3'd0);
        check("mid_wen",        wEn,        1'b0);
        check("mid_wsel",       write_sel,  5'd0);
        check("mid_wdata",      write_data, 32'h0);
        check("mid_alu_ready",  alu_ready,  1'b0);
        wr_log.delete();
        settle();
        drive_alu(1'b0, 5'd0, 32'h0);
        settle();
        reset = 1'b1;
        repeat (3) settle();
        check("mid_no_writes", wr_log.size(), 0);
        check("mid_after",     pending,       3'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
